// File: rtl/nand_test_pkg.sv
// -----------------------------------------------------------------------------
// nand_test_pkg
// Shared definitions for the NAND operation-unit self-test sequencer:
//   - state_t        : sweep sequencer states
//   - VEC_W / CNT_W  : vector index width and mismatch counter width
//   - NUM_VEC        : number of input vectors {sel, a, b}
//   - GOLDEN_DEFAULT : expected truth table of a correct operation unit
// -----------------------------------------------------------------------------
package nand_test_pkg;

   localparam int VEC_W   = 5;
   localparam int CNT_W   = 6;   // must hold 32 without wrapping
   localparam int NUM_VEC = 32;

   // bit i = expected unit output for vector i = {sel, a, b}
   localparam logic [NUM_VEC-1:0] GOLDEN_DEFAULT = 32'h33961E87;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/nand_op_sweeper_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Vector index counter plus per-vector settle down-counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : begin a sweep (index 0, settle window reloaded)
//   i_wait       : sequencer is in its settle state; count the window down
//   i_sample     : sample edge; step to the next vector and reload the window
//   o_vec_idx    : current vector index {sel, a, b}
//   o_sample_en  : settle window exhausted; the next state is the sample
//   o_last       : current vector is the final one (index 31)
// -----------------------------------------------------------------------------
module sweep_counter
   import nand_test_pkg::*;
#(
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_wait,
   input  logic             i_sample,
   output logic [VEC_W-1:0] o_vec_idx,
   output logic             o_sample_en,
   output logic             o_last
);

   // The sample state itself is one cycle of the window, so the wait state
   // only has to cover SETTLE cycles: it sits at zero for its final cycle.
   localparam logic [3:0] SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   logic [VEC_W-1:0] r_idx;
   logic [3:0]       r_settle;

   // NOTE: state registers use non-blocking assignments so every flop updates
   // from pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_settle <= '0;
      end else if (i_start) begin
         r_idx    <= '0;
         r_settle <= SETTLE_LD;
      end else if (i_sample) begin
         // Index 31 wraps to 0, which also gives the zero idle drive.
         r_idx    <= r_idx + 1'b1;
         r_settle <= SETTLE_LD;
      end else if (i_wait && (r_settle != 4'd0)) begin
         r_settle <= r_settle - 1'b1;
      end
   end

   assign o_vec_idx   = r_idx;
   assign o_sample_en = (r_settle == 4'd0);
   assign o_last      = (r_idx == VEC_W'(NUM_VEC - 1));

endmodule

// File: rtl/nand_op_sweeper.sv
// -----------------------------------------------------------------------------
// nand_op_sweeper
// Self-test sequencer for the NAND-only 2-input operation unit. Drives all 32
// vectors {sel, a, b} in order, samples the unit result after SETTLE extra
// cycles per vector, builds the truth table and compares it with GOLDEN.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : level request, sampled only in IDLE
//   dut_out     : combinational result from the operation unit
//   a, b, sel   : registered operand / op-select drives (vector index bits)
//   busy        : high from the first drive edge until the final sample edge
//   done        : one-cycle pulse when the sweep finishes
//   pass        : no mismatches; valid from done until the next start
//   err_cnt     : number of mismatching vectors (0..32)
//   first_fail  : lowest failing vector index, 0 when err_cnt == 0
//   result      : captured truth table, bit i = dut_out for vector i
// -----------------------------------------------------------------------------
module nand_op_sweeper
   import nand_test_pkg::*;
#(
   parameter int                 SETTLE = 0,
   parameter logic [NUM_VEC-1:0] GOLDEN = GOLDEN_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dut_out,
   output logic               a,
   output logic               b,
   output logic [2:0]         sel,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [VEC_W-1:0]   first_fail,
   output logic [NUM_VEC-1:0] result
);

   localparam logic HAS_WAIT = (SETTLE > 0);

   state_t r_state;
   state_t w_state_next;

   logic w_start;
   logic w_wait;
   logic w_sample;

   logic [VEC_W-1:0] w_vec_idx;
   logic             w_sample_en;
   logic             w_last;

   logic               w_mismatch;
   logic [CNT_W-1:0]   w_err_next;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [VEC_W-1:0]   r_first_fail;
   logic               r_pass;
   logic [NUM_VEC-1:0] r_result;

   sweep_counter #(
      .SETTLE (SETTLE)
   ) u_sweep_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_start),
      .i_wait      (w_wait),
      .i_sample    (w_sample),
      .o_vec_idx   (w_vec_idx),
      .o_sample_en (w_sample_en),
      .o_last      (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_wait       = 1'b0;
      w_sample     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start      = 1'b1;
               w_state_next = HAS_WAIT ? ST_WAIT : ST_SAMPLE;
            end
         end
         ST_WAIT: begin
            w_wait = 1'b1;
            if (w_sample_en) w_state_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            w_sample = 1'b1;
            if (w_last)        w_state_next = ST_DONE;
            else if (HAS_WAIT) w_state_next = ST_WAIT;
            else               w_state_next = ST_SAMPLE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Compare against the index that is being driven right now (registered),
   // not the index the counter is about to step to.
   assign w_mismatch = dut_out ^ GOLDEN[w_vec_idx];
   assign w_err_next = r_err_cnt + {{(CNT_W-1){1'b0}}, w_mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result     <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
         r_pass       <= 1'b0;
      end else if (w_start) begin
         r_result     <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
         r_pass       <= 1'b0;
      end else if (w_sample) begin
         r_result[w_vec_idx] <= dut_out;
         r_err_cnt           <= w_err_next;
         if (w_mismatch && (r_err_cnt == '0)) r_first_fail <= w_vec_idx;
         // Verdict lands on the edge that enters DONE so it is valid with done.
         if (w_last) r_pass <= (w_err_next == '0);
      end
   end

   assign sel        = w_vec_idx[4:2];
   assign a          = w_vec_idx[1];
   assign b          = w_vec_idx[0];
   assign busy       = (r_state == ST_WAIT) || (r_state == ST_SAMPLE);
   assign done       = (r_state == ST_DONE);
   assign pass       = r_pass;
   assign err_cnt    = r_err_cnt;
   assign first_fail = r_first_fail;
   assign result     = r_result;

endmodule

// File: tb/tb_nand_op_sweeper.sv
// -----------------------------------------------------------------------------
// tb_nand_op_sweeper
// Self-checking bench: two sweepers (SETTLE=0 and SETTLE=2), each closing the
// loop through a behavioural operation-unit model that can be healthy, stuck
// at 0, or have op 6 return a instead of NOT a. Expected sweep outcomes are
// pushed to a scoreboard queue at start and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_nand_op_sweeper;

   localparam logic [31:0] GOLD_TT = 32'h33961E87;
   localparam int          S2      = 2;

   typedef struct {
      logic [31:0] res;
      int          err;
      int          ff;
      logic        pass;
      int          k;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SETTLE = 0 instance
   logic        start0, dut_out0, a0, b0, busy0, done0, pass0;
   logic [2:0]  sel0;
   logic [5:0]  err0;
   logic [4:0]  ff0;
   logic [31:0] result0;
   int          mode0;

   // SETTLE = 2 instance
   logic        start2, dut_out2, a2, b2, busy2, done2, pass2;
   logic [2:0]  sel2;
   logic [5:0]  err2;
   logic [4:0]  ff2;
   logic [31:0] result2;
   int          mode2;

   exp_t q0[$];
   exp_t q2[$];
   exp_t last_e0;

   int n_checks = 0;
   int n_pass   = 0;

   // mode 0: healthy unit, 1: output stuck at 0, 2: op 6 returns a
   function automatic logic unit(input logic [2:0] s, input logic ia,
                                 input logic ib, input int mode);
      logic r;
      case (s)
         3'd0:    r = ~(ia & ib);
         3'd1:    r = ia & ib;
         3'd2:    r = ia | ib;
         3'd3:    r = ~(ia | ib);
         3'd4:    r = ia ^ ib;
         3'd5:    r = ~(ia ^ ib);
         3'd6:    r = (mode == 2) ? ia : ~ia;
         default: r = ~ia;
      endcase
      if (mode == 1) r = 1'b0;
      return r;
   endfunction

   function automatic exp_t build_exp(input int mode, input int k, input int settle);
      exp_t        e;
      logic [4:0]  v;
      logic [31:0] g;
      g     = GOLD_TT;
      e.res = '0;
      e.err = 0;
      e.ff  = 0;
      for (int i = 0; i < 32; i++) begin
         v        = 5'(i);
         e.res[i] = unit(v[4:2], v[1], v[0], mode);
         if (e.res[i] != g[i]) begin
            if (e.err == 0) e.ff = i;
            e.err++;
         end
      end
      e.pass = (e.err == 0);
      e.k    = k;
      e.lat  = 32 * (settle + 1);
      return e;
   endfunction

   assign dut_out0 = unit(sel0, a0, b0, mode0);
   assign dut_out2 = unit(sel2, a2, b2, mode2);

   nand_op_sweeper #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut_out0),
      .a(a0), .b(b0), .sel(sel0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .first_fail(ff0), .result(result0)
   );

   nand_op_sweeper #(.SETTLE(S2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dut_out2),
      .a(a2), .b(b2), .sel(sel2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .first_fail(ff2), .result(result2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // One-cycle start pulse on the SETTLE=0 instance; returns at the negedge
   // just after the start edge (vector 0 being driven).
   task automatic start0_sweep(input int mode);
      @(negedge clk);
      mode0  = mode;
      start0 = 1'b1;
      q0.push_back(build_exp(mode, cyc + 1, 0));
      @(negedge clk);
      start0 = 1'b0;
   endtask

   // Waits (bounded) for done on the chosen instance, then pops and compares.
   task automatic wait_done(input int which, input int budget);
      exp_t e;
      bit   seen;
      seen = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if ((which == 0) ? done0 : done2) seen = 1;
      end
      check("done_seen", 32'(seen), 32'd1);
      if (!seen) return;
      if (which == 0) begin
         check("sb_nonempty0", 32'(q0.size() != 0), 32'd1);
         if (q0.size() == 0) return;
         e = q0.pop_front();
         last_e0 = e;
         check("result0",     result0,      e.res);
         check("err_cnt0",    32'(err0),    32'(e.err));
         check("first_fail0", 32'(ff0),     32'(e.ff));
         check("pass0",       32'(pass0),   32'(e.pass));
         check("latency0",    32'(cyc - e.k), 32'(e.lat));
         check("busy_at_done0", 32'(busy0), 32'd0);
      end else begin
         check("sb_nonempty2", 32'(q2.size() != 0), 32'd1);
         if (q2.size() == 0) return;
         e = q2.pop_front();
         check("result2",     result2,      e.res);
         check("err_cnt2",    32'(err2),    32'(e.err));
         check("first_fail2", 32'(ff2),     32'(e.ff));
         check("pass2",       32'(pass2),   32'(e.pass));
         check("latency2",    32'(cyc - e.k), 32'(e.lat));
         check("busy_at_done2", 32'(busy2), 32'd0);
      end
   endtask

   initial begin
      int  k;
      bit  found;
      exp_t dropped;

      rst_n  = 1'b0;
      start0 = 1'b0;
      start2 = 1'b0;
      mode0  = 0;
      mode2  = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_ctl0", 32'({busy0, done0, pass0, a0, b0, sel0, err0, ff0}), 32'd0);
      check("rst_result0", result0, 32'd0);
      check("rst_ctl2", 32'({busy2, done2, pass2, a2, b2, sel2, err2, ff2}), 32'd0);
      check("rst_result2", result2, 32'd0);

      // Healthy unit, SETTLE=0
      start0_sweep(0);
      check("busy_mid0", 32'(busy0), 32'd1);
      wait_done(0, 40);
      repeat (3) @(negedge clk);
      check("hold_pass0", 32'(pass0), 32'(last_e0.pass));
      check("hold_result0", result0, last_e0.res);
      check("idle_drive0", 32'({sel0, a0, b0}), 32'd0);

      // Output stuck at 0
      start0_sweep(1);
      wait_done(0, 40);
      repeat (3) @(negedge clk);
      check("hold_err0", 32'(err0), 32'(last_e0.err));

      // Op 6 returns a instead of NOT a
      start0_sweep(2);
      wait_done(0, 40);
      check("fault_nibble0", 32'(result0[27:24]), 32'hC);

      // SETTLE=2: each vector held for 3 cycles
      @(negedge clk);
      mode2  = 0;
      start2 = 1'b1;
      q2.push_back(build_exp(0, cyc + 1, S2));
      @(negedge clk);
      start2 = 1'b0;
      k = cyc;
      check("busy_mid2", 32'(busy2), 32'd1);
      for (int j = 0; j < 12; j++) begin
         check("step2", 32'({sel2, a2, b2}), 32'((cyc - k) / 3));
         @(negedge clk);
      end
      wait_done(2, 120);

      // Asynchronous reset mid-sweep at vector 10
      start0_sweep(0);
      found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
         if ({sel0, a0, b0} == 5'd10) found = 1;
         else @(negedge clk);
      end
      check("reached_idx10", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl0", 32'({busy0, done0, pass0, a0, b0, sel0, err0, ff0}), 32'd0);
      check("arst_result0", result0, 32'd0);
      if (q0.size() != 0) dropped = q0.pop_front();
      repeat (2) @(negedge clk);
      check("arst_no_done0", 32'(done0), 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("arst_still_idle0", 32'({busy0, done0}), 32'd0);
      start0_sweep(0);
      wait_done(0, 40);

      // start held high: back-to-back sweeps every 34 cycles
      @(negedge clk);
      mode0  = 0;
      start0 = 1'b1;
      k = cyc + 1;
      for (int n = 0; n < 3; n++) q0.push_back(build_exp(0, k + 34 * n, 0));
      wait_done(0, 40);
      wait_done(0, 40);
      wait_done(0, 40);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b_stopped0", 32'({busy0, done0}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
